// File: rtl/lane_req_sync_if.sv
// Launcher/lane side signals of lane_req_sync: broadcast request path and VFU done path.
interface lane_req_sync_if #(
  parameter int unsigned NrLane    = 4,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned NrVfu     = 3,
  parameter int unsigned IdWidth   = 3
);
  logic                                         req_valid_i;
  logic                                         req_ready_o;
  logic [DataWidth-1:0]                         req_data_i;
  logic [NrLane-1:0]                            lane_valid_o;
  logic [NrLane-1:0]                            lane_ready_i;
  logic [NrLane-1:0][DataWidth-1:0]             lane_data_o;
  logic [NrLane-1:0][NrVfu-1:0]                 done_i;
  logic [NrLane-1:0][NrVfu-1:0][IdWidth-1:0]    done_id_i;
  logic [NrLane-1:0][NrVfu-1:0]                 done_gnt_o;
  logic [NrVfu-1:0]                             done_o;
  logic [NrVfu-1:0][IdWidth-1:0]                done_id_o;
  logic [NrVfu-1:0]                             done_gnt_i;
  logic [NrVfu-1:0]                             id_mismatch_o;

  // Launcher and lanes drive the inputs of the synchroniser.
  modport master (
    output req_valid_i, req_data_i, lane_ready_i, done_i, done_id_i, done_gnt_i,
    input  req_ready_o, lane_valid_o, lane_data_o, done_gnt_o, done_o, done_id_o,
           id_mismatch_o
  );

  modport slave (
    input  req_valid_i, req_data_i, lane_ready_i, done_i, done_id_i, done_gnt_i,
    output req_ready_o, lane_valid_o, lane_data_o, done_gnt_o, done_o, done_id_o,
           id_mismatch_o
  );
endinterface

// File: rtl/lane_req_sync.sv
// Buffered launcher-to-lane synchroniser: per-lane request FIFOs plus per-VFU
// completion gathering with a lane-ID consistency check.
module lane_req_sync #(
  parameter int unsigned NrLane    = 4,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned Depth     = 2,
  parameter int unsigned NrVfu     = 3,
  parameter int unsigned IdWidth   = 3
) (
  input logic           clk_i,
  input logic           rst_i,
  lane_req_sync_if.slave bus
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  logic [DataWidth-1:0] mem    [NrLane][Depth];
  logic [PtrW-1:0]      wr_ptr [NrLane];
  logic [PtrW-1:0]      rd_ptr [NrLane];
  logic [CntW-1:0]      cnt    [NrLane];

  logic                             all_space;
  logic                             push;
  logic [NrLane-1:0]                pop;
  logic [NrLane-1:0]                lane_valid;
  logic [NrLane-1:0][DataWidth-1:0] lane_data;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  // Ready only looks at registered counts so lanes never feed back into the launcher.
  always_comb begin
    all_space  = 1'b1;
    lane_valid = '0;
    lane_data  = '0;
    pop        = '0;
    for (int l = 0; l < NrLane; l++) begin
      if (cnt[l] == FullCnt) all_space = 1'b0;
      lane_valid[l] = (cnt[l] != '0) && !rst_i;
      lane_data[l]  = mem[l][rd_ptr[l]];
      pop[l]        = lane_valid[l] && bus.lane_ready_i[l];
    end
  end

  assign bus.req_ready_o  = !rst_i && all_space;
  assign push             = bus.req_valid_i && bus.req_ready_o;
  assign bus.lane_valid_o = lane_valid;
  assign bus.lane_data_o  = lane_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int l = 0; l < NrLane; l++) begin
        wr_ptr[l] <= '0;
        rd_ptr[l] <= '0;
        cnt[l]    <= '0;
      end
    end else begin
      for (int l = 0; l < NrLane; l++) begin
        if (push)   wr_ptr[l] <= next_ptr(wr_ptr[l]);
        if (pop[l]) rd_ptr[l] <= next_ptr(rd_ptr[l]);
        case ({push, pop[l]})
          2'b10:   cnt[l] <= cnt[l] + CntW'(1);
          2'b01:   cnt[l] <= cnt[l] - CntW'(1);
          default: cnt[l] <= cnt[l];
        endcase
      end
    end
  end

  // Payload storage carries no reset; validity comes from the counts.
  always_ff @(posedge clk_i) begin
    if (push) begin
      for (int l = 0; l < NrLane; l++) mem[l][wr_ptr[l]] <= bus.req_data_i;
    end
  end

  logic [NrLane-1:0][NrVfu-1:0]              col;
  logic [NrLane-1:0][NrVfu-1:0][IdWidth-1:0] cid;
  logic [NrLane-1:0][NrVfu-1:0]              gnt;
  logic [NrVfu-1:0]                          done_all;
  logic [NrVfu-1:0]                          id_diff;
  logic [NrVfu-1:0]                          ack;
  logic [NrVfu-1:0]                          mismatch_q;
  logic [NrVfu-1:0][IdWidth-1:0]             done_id;

  // A lane is granted once per collection round; the round closes on the launcher ack.
  always_comb begin
    gnt      = '0;
    done_all = '1;
    id_diff  = '0;
    done_id  = '0;
    for (int v = 0; v < NrVfu; v++) begin
      done_id[v] = cid[0][v];
      for (int l = 0; l < NrLane; l++) begin
        gnt[l][v] = bus.done_i[l][v] && !col[l][v] && !rst_i;
        if (!col[l][v]) done_all[v] = 1'b0;
        if (cid[l][v] != cid[0][v]) id_diff[v] = 1'b1;
      end
    end
    if (rst_i) done_all = '0;
  end

  assign ack               = done_all & bus.done_gnt_i;
  assign bus.done_gnt_o    = gnt;
  assign bus.done_o        = done_all;
  assign bus.done_id_o     = done_id;
  assign bus.id_mismatch_o = rst_i ? '0 : mismatch_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col        <= '0;
      mismatch_q <= '0;
    end else begin
      for (int v = 0; v < NrVfu; v++) begin
        for (int l = 0; l < NrLane; l++) begin
          if (ack[v])         col[l][v] <= 1'b0;
          else if (gnt[l][v]) col[l][v] <= 1'b1;
        end
      end
      mismatch_q <= mismatch_q | (ack & id_diff);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int l = 0; l < NrLane; l++) begin
      for (int v = 0; v < NrVfu; v++) begin
        if (gnt[l][v]) cid[l][v] <= bus.done_id_i[l][v];
      end
    end
  end
endmodule

// File: tb/tb_lane_req_sync.sv
// Self-checking bench for lane_req_sync: FIFO data scoreboard plus per-scenario done-path checks.
module tb_lane_req_sync;
  localparam int unsigned NL = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned DP = 2;
  localparam int unsigned NV = 3;
  localparam int unsigned IW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  lane_req_sync_if #(.NrLane(NL), .DataWidth(DW), .NrVfu(NV), .IdWidth(IW)) bus ();

  lane_req_sync #(.NrLane(NL), .DataWidth(DW), .Depth(DP), .NrVfu(NV), .IdWidth(IW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] exp_q [NL][$];

  // Scoreboard: expected payloads queued on accept, compared on every lane pop.
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      for (int l = 0; l < NL; l++) exp_q[l].delete();
    end else begin
      for (int l = 0; l < NL; l++) begin
        if (bus.lane_valid_o[l] && bus.lane_ready_i[l]) begin
          checks++;
          if (exp_q[l].size() == 0) begin
            errors++;
            $display("FAIL lane%0d_pop_unexpected: got data %h, no entry expected", l, bus.lane_data_o[l]);
          end else begin
            logic [DW-1:0] e;
            e = exp_q[l].pop_front();
            if (bus.lane_data_o[l] !== e) begin
              errors++;
              $display("FAIL lane%0d_data: got %h expected %h", l, bus.lane_data_o[l], e);
            end
          end
        end
      end
      if (bus.req_valid_i && bus.req_ready_o)
        for (int l = 0; l < NL; l++) exp_q[l].push_back(bus.req_data_i);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic idle();
    bus.req_valid_i  = 1'b0;
    bus.req_data_i   = '0;
    bus.lane_ready_i = '0;
    bus.done_i       = '0;
    bus.done_id_i    = '0;
    bus.done_gnt_i   = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    bus.done_i = '1;
    @(negedge clk);
    #1;
    checks++; if (bus.req_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", bus.req_ready_o); end
    checks++; if (bus.lane_valid_o !== '0) begin errors++; $display("FAIL rst_lane_valid: got %h expected 0", bus.lane_valid_o); end
    checks++; if (bus.done_o !== '0) begin errors++; $display("FAIL rst_done: got %h expected 0", bus.done_o); end
    checks++; if (bus.done_gnt_o !== '0) begin errors++; $display("FAIL rst_gnt: got %h expected 0", bus.done_gnt_o); end
    checks++; if (bus.id_mismatch_o !== '0) begin errors++; $display("FAIL rst_mismatch: got %h expected 0", bus.id_mismatch_o); end
    step(2);
    rst = 1'b0;
    bus.done_i = '0;
    #1;
    checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b expected 1", bus.req_ready_o); end
    checks++; if (bus.lane_valid_o !== '0) begin errors++; $display("FAIL post_rst_lane_valid: got %h expected 0", bus.lane_valid_o); end
  endtask

  task automatic test_broadcast();
    logic [DW-1:0] vals [3];
    vals[0] = 64'hA; vals[1] = 64'hB; vals[2] = 64'hC;
    bus.lane_ready_i = 4'hF;
    for (int i = 0; i < 3; i++) begin
      bus.req_valid_i = 1'b1;
      bus.req_data_i  = vals[i];
      #1;
      checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL bc_ready%0d: got %b expected 1", i, bus.req_ready_o); end
      checks++;
      if (bus.lane_valid_o !== ((i == 0) ? 4'h0 : 4'hF)) begin
        errors++; $display("FAIL bc_valid%0d: got %h expected %h", i, bus.lane_valid_o, (i == 0) ? 4'h0 : 4'hF);
      end
      step();
    end
    bus.req_valid_i = 1'b0;
    #1;
    checks++; if (bus.lane_valid_o !== 4'hF) begin errors++; $display("FAIL bc_last_valid: got %h expected f", bus.lane_valid_o); end
    step();
    #1;
    checks++; if (bus.lane_valid_o !== 4'h0) begin errors++; $display("FAIL bc_drained: got %h expected 0", bus.lane_valid_o); end
    idle();
  endtask

  task automatic test_back_to_back();
    bus.lane_ready_i = 4'h0;
    for (int i = 0; i < 3; i++) begin
      bus.req_valid_i = 1'b1;
      bus.req_data_i  = DW'(64'hD0 + i);
      #1;
      checks++;
      if (bus.req_ready_o !== ((i < int'(DP)) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL b2b_ready%0d: got %b expected %b", i, bus.req_ready_o, (i < int'(DP)));
      end
      step();
    end
    bus.req_valid_i  = 1'b0;
    bus.lane_ready_i = 4'hF;
    step();
    #1;
    checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_pop: got %b expected 1", bus.req_ready_o); end
    step(2);
    checks++; if (bus.lane_valid_o !== 4'h0) begin errors++; $display("FAIL b2b_drained: got %h expected 0", bus.lane_valid_o); end
    idle();
  endtask

  task automatic test_skew();
    logic exp_rdy [6];
    exp_rdy[0] = 1; exp_rdy[1] = 1; exp_rdy[2] = 0; exp_rdy[3] = 0; exp_rdy[4] = 0; exp_rdy[5] = 1;
    bus.req_valid_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus.lane_ready_i = (c == 4) ? 4'hF : 4'b1011;
      bus.req_data_i   = DW'(64'h100 + ((c < 2) ? c : 2));
      #1;
      checks++;
      if (bus.req_ready_o !== exp_rdy[c]) begin
        errors++; $display("FAIL skew_ready_c%0d: got %b expected %b", c, bus.req_ready_o, exp_rdy[c]);
      end
      step();
    end
    bus.req_valid_i  = 1'b0;
    bus.lane_ready_i = 4'hF;
    step(3);
    checks++; if (bus.lane_valid_o !== 4'h0) begin errors++; $display("FAIL skew_drained: got %h expected 0", bus.lane_valid_o); end
    idle();
  endtask

  task automatic test_done_agg();
    int t [NL];
    logic [NL-1:0][NV-1:0] eg;
    t[0] = 0; t[1] = 3; t[2] = 3; t[3] = 7;
    for (int c = 0; c < 10; c++) begin
      eg = '0;
      for (int l = 0; l < NL; l++) begin
        bus.done_id_i[l][1] = IW'(5);
        bus.done_i[l][1]    = (c >= t[l]) && (c < 8);
        eg[l][1]            = (c == t[l]);
      end
      bus.done_gnt_i = (c == 8) ? 3'b010 : 3'b000;
      #1;
      checks++; if (bus.done_gnt_o !== eg) begin errors++; $display("FAIL agg_gnt_c%0d: got %h expected %h", c, bus.done_gnt_o, eg); end
      checks++;
      if (bus.done_o !== ((c == 8) ? 3'b010 : 3'b000)) begin
        errors++; $display("FAIL agg_done_c%0d: got %b expected %b", c, bus.done_o, (c == 8) ? 3'b010 : 3'b000);
      end
      if (c == 8) begin
        checks++; if (bus.done_id_o[1] !== IW'(5)) begin errors++; $display("FAIL agg_id: got %0d expected 5", bus.done_id_o[1]); end
      end
      step();
    end
    checks++; if (bus.id_mismatch_o !== 3'b000) begin errors++; $display("FAIL agg_mismatch: got %b expected 000", bus.id_mismatch_o); end
    idle();
  endtask

  task automatic test_redone();
    logic [NL-1:0][NV-1:0] eg;
    for (int l = 0; l < NL; l++) begin bus.done_i[l][0] = 1'b1; bus.done_id_i[l][0] = IW'(5); end
    #1;
    eg = '0; for (int l = 0; l < NL; l++) eg[l][0] = 1'b1;
    checks++; if (bus.done_gnt_o !== eg) begin errors++; $display("FAIL redo_first_gnt: got %h expected %h", bus.done_gnt_o, eg); end
    step();
    bus.done_i = '0;
    bus.done_i[0][0] = 1'b1; bus.done_id_i[0][0] = IW'(6);
    for (int c = 0; c < 3; c++) begin
      bus.done_gnt_i = (c == 2) ? 3'b001 : 3'b000;
      #1;
      checks++; if (bus.done_gnt_o !== '0) begin errors++; $display("FAIL redo_blocked_c%0d: got %h expected 0", c, bus.done_gnt_o); end
      checks++; if (bus.done_o !== 3'b001) begin errors++; $display("FAIL redo_pending_c%0d: got %b expected 001", c, bus.done_o); end
      checks++; if (bus.done_id_o[0] !== IW'(5)) begin errors++; $display("FAIL redo_id5_c%0d: got %0d expected 5", c, bus.done_id_o[0]); end
      step();
    end
    bus.done_gnt_i = '0;
    #1;
    eg = '0; eg[0][0] = 1'b1;
    checks++; if (bus.done_gnt_o !== eg) begin errors++; $display("FAIL redo_gnt_after_ack: got %h expected %h", bus.done_gnt_o, eg); end
    checks++; if (bus.done_o !== 3'b000) begin errors++; $display("FAIL redo_done_low: got %b expected 000", bus.done_o); end
    step();
    bus.done_i = '0;
    for (int l = 1; l < NL; l++) begin bus.done_i[l][0] = 1'b1; bus.done_id_i[l][0] = IW'(6); end
    step();
    bus.done_i = '0;
    bus.done_gnt_i = 3'b001;
    #1;
    checks++; if (bus.done_o !== 3'b001) begin errors++; $display("FAIL redo_done6: got %b expected 001", bus.done_o); end
    checks++; if (bus.done_id_o[0] !== IW'(6)) begin errors++; $display("FAIL redo_id6: got %0d expected 6", bus.done_id_o[0]); end
    step();
    bus.done_gnt_i = '0;
    #1;
    checks++; if (bus.done_o !== 3'b000) begin errors++; $display("FAIL redo_done_clear: got %b expected 000", bus.done_o); end
    checks++; if (bus.id_mismatch_o !== 3'b000) begin errors++; $display("FAIL redo_mismatch: got %b expected 000", bus.id_mismatch_o); end
    idle();
  endtask

  task automatic test_mismatch();
    for (int l = 0; l < NL; l++) begin
      bus.done_i[l][2]    = 1'b1;
      bus.done_id_i[l][2] = (l == 2) ? IW'(3) : IW'(2);
    end
    step();
    bus.done_i = '0;
    bus.done_gnt_i = 3'b100;
    #1;
    checks++; if (bus.done_o !== 3'b100) begin errors++; $display("FAIL mm_done: got %b expected 100", bus.done_o); end
    checks++; if (bus.done_id_o[2] !== IW'(2)) begin errors++; $display("FAIL mm_id: got %0d expected 2", bus.done_id_o[2]); end
    checks++; if (bus.id_mismatch_o !== 3'b000) begin errors++; $display("FAIL mm_before_ack: got %b expected 000", bus.id_mismatch_o); end
    step();
    bus.done_gnt_i = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (bus.id_mismatch_o !== 3'b100) begin errors++; $display("FAIL mm_sticky_c%0d: got %b expected 100", c, bus.id_mismatch_o); end
      checks++; if (bus.done_o !== 3'b000) begin errors++; $display("FAIL mm_done_low_c%0d: got %b expected 000", c, bus.done_o); end
      step();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    logic [NL-1:0][NV-1:0] eg;
    bus.req_valid_i = 1'b1;
    bus.req_data_i  = 64'hBEEF;
    step();
    bus.req_valid_i = 1'b0;
    bus.done_i[0][0] = 1'b1; bus.done_i[1][0] = 1'b1;
    bus.done_id_i[0][0] = IW'(1); bus.done_id_i[1][0] = IW'(1);
    step();
    bus.done_i = '0;
    bus.done_i[2][0] = 1'b1; bus.done_i[3][0] = 1'b1;
    bus.done_id_i[2][0] = IW'(1); bus.done_id_i[3][0] = IW'(1);
    rst = 1'b1;
    #1;
    checks++; if (bus.lane_valid_o !== '0) begin errors++; $display("FAIL rm_valid_in_rst: got %h expected 0", bus.lane_valid_o); end
    checks++; if (bus.req_ready_o !== 1'b0) begin errors++; $display("FAIL rm_ready_in_rst: got %b expected 0", bus.req_ready_o); end
    checks++; if (bus.done_gnt_o !== '0) begin errors++; $display("FAIL rm_gnt_in_rst: got %h expected 0", bus.done_gnt_o); end
    checks++; if (bus.done_o !== '0) begin errors++; $display("FAIL rm_done_in_rst: got %b expected 0", bus.done_o); end
    checks++; if (bus.id_mismatch_o !== '0) begin errors++; $display("FAIL rm_mm_in_rst: got %b expected 0", bus.id_mismatch_o); end
    step();
    rst = 1'b0;
    #1;
    eg = '0; eg[2][0] = 1'b1; eg[3][0] = 1'b1;
    checks++; if (bus.lane_valid_o !== '0) begin errors++; $display("FAIL rm_valid_after: got %h expected 0", bus.lane_valid_o); end
    checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL rm_ready_after: got %b expected 1", bus.req_ready_o); end
    checks++; if (bus.id_mismatch_o !== '0) begin errors++; $display("FAIL rm_mm_after: got %b expected 0", bus.id_mismatch_o); end
    checks++; if (bus.done_gnt_o !== eg) begin errors++; $display("FAIL rm_gnt_after: got %h expected %h", bus.done_gnt_o, eg); end
    step();
    bus.done_i = '0;
    #1;
    checks++; if (bus.done_o !== '0) begin errors++; $display("FAIL rm_partial_discarded: got %b expected 0", bus.done_o); end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_broadcast();
    test_back_to_back();
    test_skew();
    test_done_agg();
    test_redone();
    test_mismatch();
    test_reset_mid();
    step(2);
    for (int l = 0; l < NL; l++) begin
      checks++;
      if (exp_q[l].size() != 0) begin
        errors++; $display("FAIL lane%0d_leftover: got %0d entries expected 0", l, exp_q[l].size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lane_req_sync.md
# lane_req_sync

Buffered, parametrised synchroniser between the single vector instruction launcher and `NrLane` lanes. Broadcast requests, such as operand or VFU requests, enter per-lane FIFOs, so lanes consume the same request on different cycles instead of waiting for a global all-ready. Per-VFU completions from all lanes are gathered into one done/ID handshake toward the launcher, with a lane-ID consistency check. It replaces the combinational AND-of-readies lane wrapper.

## Interface
- `NrLane`, 4, number of lanes (≥1)
- `DataWidth`, 64, width of one broadcast request payload
- `Depth`, 2, entries per lane FIFO (≥1, any integer)
- `NrVfu`, 3, VFUs per lane
- `IdWidth`, 3, instruction ID width
- `clk_i` in 1, clock
- `rst_i` in 1, reset. One clock; reset is synchronous and active-high.
- `req_valid_i` in 1, broadcast request valid
- `req_ready_o` out 1, request accepted into every lane FIFO
- `req_data_i` in `DataWidth`, request payload
- `lane_valid_o` out `NrLane`, per-lane FIFO non-empty
- `lane_ready_i` in `NrLane`, lane consumes its FIFO head
- `lane_data_o` out `NrLane`×`DataWidth`, per-lane FIFO head
- `done_i` in `NrLane`×`NrVfu`, lane VFU completion valid
- `done_id_i` in `NrLane`×`NrVfu`×`IdWidth`, ID of completed instruction
- `done_gnt_o` out `NrLane`×`NrVfu`, completion captured
- `done_o` out `NrVfu`, all lanes completed for that VFU
- `done_id_o` out `NrVfu`×`IdWidth`, ID captured from lane 0
- `done_gnt_i` in `NrVfu`, launcher acknowledges `done_o`
- `id_mismatch_o` out `NrVfu`, sticky error: lanes reported different IDs

## Operation
- **Broadcast path:** one FIFO per lane, `Depth` entries, with read/write pointers that wrap from `Depth-1` to 0 and a count of width `$clog2(Depth+1)`.
  - `req_ready_o = !rst_i && every FIFO count < Depth`.
  - `req_ready_o` depends only on registered counts, never on `lane_ready_i`.
  - A handshake (`req_valid_i && req_ready_o`) writes `req_data_i` into all `NrLane` FIFOs in the same cycle.
  - `lane_valid_o[l] = count[l] != 0`; `lane_data_o[l]` is the head entry, registered storage.
  - Pop on `lane_valid_o[l] && lane_ready_i[l]`.
  - Simultaneous push and pop on one FIFO: count unchanged, both pointers advance.
  - A full FIFO being popped still blocks push in that cycle.
  - `lane_data_o` while `lane_valid_o` is low: don't-care.
- **Done path**, per VFU `v`: collected bits `col[l][v]` and stored IDs `cid[l][v]`.
  - `done_gnt_o[l][v] = done_i[l][v] && !col[l][v] && !rst_i`.
  - On grant, set `col[l][v]` and store `cid[l][v] = done_id_i[l][v]`.
  - `done_o[v] = &col[*][v]` (registered). `done_id_o[v] = cid[0][v]`.
  - `done_o[v] && done_gnt_i[v]` clears all `col[*][v]`.
  - In that same cycle, `done_gnt_o[*][v]` stays 0 because the bits are still set. New completions are granted from the next cycle.
  - On that handshake, if any `cid[l][v] != cid[0][v]`, set `id_mismatch_o[v]`. It stays set until reset.
  - VFUs are fully independent.
  - `done_gnt_i[v]` while `done_o[v]` is low is ignored.
- **Reset:**
  - All FIFOs empty and all `col` bits clear, so `lane_valid_o`, `done_o`, `done_gnt_o`, `req_ready_o` and `id_mismatch_o` are 0.
  - `lane_data_o`, `done_id_o` and `cid` values are don't-care.
  - Reset mid-operation discards buffered requests and partial collections without emitting them.

## Timing
- Request accepted at edge N → `lane_valid_o` high for all lanes after edge N (cycle N+1).
- Per-lane throughput is 1 request/cycle.
- `Depth` requests can be accepted back-to-back with no lane consuming; the next is blocked.
- After the slowest lane pops from a full FIFO at edge N, `req_ready_o` rises in cycle N+1.
- Last lane completion granted in cycle N → `done_o[v]` high in cycle N+1.
- `done_gnt_i[v]` in cycle M → `done_o[v]` low in M+1, and lanes can be granted in M+1.
- `id_mismatch_o` rises the cycle after the mismatching handshake.
- First cycle after `rst_i` deasserts: `req_ready_o` = 1.

## Test plan
- **Broadcast, all ready:** `NrLane`=4, `Depth`=2, `lane_ready_i`=4'hF, push 0xA, 0xB, 0xC on consecutive cycles → each lane emits A, B, C in order, one cycle after each push, with `req_ready_o` held at 1.
- **Skew / full:** lane 2 ready low, 3 pushes → third blocked (`req_ready_o`=0 after 2). Raise lane 2 ready for 1 cycle → `req_ready_o`=1 the next cycle. Lane 2 still outputs the sequence in order.
- **Done aggregation:** VFU 1, lanes complete ID 5 on cycles 0, 3, 3, 7 → each `done_gnt_o` is a single cycle. `done_o[1]`=1 at cycle 8 with `done_id_o`=5. Ack at 8 → `done_o[1]`=0 at 9.
- **Re-done while pending:** lane 0 asserts `done_i` for ID 6 while `done_o` for ID 5 is pending → no grant until the cycle after the ack. ID 6 is then collected correctly.
- **Mismatch:** lanes report IDs 2, 2, 3, 2 → `done_o` with `done_id_o`=2. After the ack, `id_mismatch_o[v]`=1 and stays 1 until `rst_i`.
- **Reset mid-operation:** FIFOs half-full with 2 of 4 lanes collected, assert `rst_i` for 1 cycle → all outputs 0 during reset. Afterwards FIFOs are empty, no `done_o`, and `req_ready_o`=1.
